// File: rtl/race_ctrl_if.sv
// Signal bundle between the race sequencer and the display/HUD pipeline.
// BEST_LAP_EN adds the best_lap HUD field.
interface race_ctrl_if;
    logic       frame_tick;
    logic       btn_start;
    logic       lap_cross;
    logic       bg_visible;
    logic       track_visible;
    logic       player_visible;
    logic       player_enable;
    logic [1:0] game_state;
    logic [2:0] countdown;
    logic [3:0] lap_cnt;
    logic [9:0] race_time;
    logic       finished;
`ifdef BEST_LAP_EN
    logic [9:0] best_lap;
`endif

    modport master (
        output frame_tick, btn_start, lap_cross,
        input  bg_visible, track_visible, player_visible, player_enable,
        input  game_state, countdown, lap_cnt, race_time, finished
`ifdef BEST_LAP_EN
        , input best_lap
`endif
    );

    modport slave (
        input  frame_tick, btn_start, lap_cross,
        output bg_visible, track_visible, player_visible, player_enable,
        output game_state, countdown, lap_cnt, race_time, finished
`ifdef BEST_LAP_EN
        , output best_lap
`endif
    );
endinterface

// File: rtl/race_ctrl.sv
// Race phase sequencer: idle -> countdown -> race -> finished, driving layer
// enables and HUD counters. Define BEST_LAP_EN to add the best-lap timer.
module race_ctrl #(
    parameter int FRAMES_PER_SEC  = 60,
    parameter int COUNTDOWN_SEC   = 3,
    parameter int LAPS            = 3,
    parameter int FINISH_HOLD_SEC = 5
) (
    input logic        pclk,
    input logic        rst,
    race_ctrl_if.slave ctrl_io
);
    localparam int PW = $clog2(FRAMES_PER_SEC);

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_COUNTDOWN = 2'b01;
    localparam logic [1:0] ST_RACE      = 2'b11;
    localparam logic [1:0] ST_FINISHED  = 2'b10;
    localparam logic [9:0] TIME_MAX     = 10'd999;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    hold_q, hold_d;
    logic [2:0]    countdown_q, countdown_d;
    logic [3:0]    lap_q, lap_d;
    logic [9:0]    time_q, time_d;
    logic          finished_q, finished_d;
    logic          bg_q, track_q, player_q, enable_q;
    logic          btn_start_q;
    logic          start_edge, sec_tick;

    assign start_edge = ctrl_io.btn_start & ~btn_start_q;
    assign sec_tick   = ctrl_io.frame_tick && (presc_q == PW'(FRAMES_PER_SEC - 1));

    always_comb begin
        state_d     = state_q;
        countdown_d = countdown_q;
        lap_d       = lap_q;
        time_d      = time_q;
        hold_d      = hold_q;
        finished_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d     = ST_COUNTDOWN;
                    countdown_d = 3'(COUNTDOWN_SEC);
                    lap_d       = '0;
                    time_d      = '0;
                end
            end
            ST_COUNTDOWN: begin
                if (sec_tick) begin
                    countdown_d = countdown_q - 3'd1;
                    if (countdown_q == 3'd1) state_d = ST_RACE;
                end
            end
            ST_RACE: begin
                if (sec_tick && time_q != TIME_MAX) time_d = time_q + 10'd1;
                if (ctrl_io.lap_cross) begin
                    lap_d = lap_q + 4'd1;
                    if (lap_q == 4'(LAPS - 1)) begin
                        state_d    = ST_FINISHED;
                        finished_d = 1'b1;
                    end
                end
            end
            ST_FINISHED: begin
                // Button and hold timeout in the same cycle collapse into one exit
                if (start_edge || (sec_tick && hold_q == 6'(FINISH_HOLD_SEC - 1)))
                    state_d = ST_IDLE;
                else if (sec_tick)
                    hold_d = hold_q + 6'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        presc_d = presc_q;
        if (state_d != state_q) begin
            presc_d = '0;
            hold_d  = '0;
        end else if (ctrl_io.frame_tick) begin
            presc_d = sec_tick ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        // Sampled through reset so a button held across reset gives no edge
        btn_start_q <= ctrl_io.btn_start;
        if (rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            hold_q      <= '0;
            countdown_q <= '0;
            lap_q       <= '0;
            time_q      <= '0;
            finished_q  <= 1'b0;
            bg_q        <= 1'b1;
            track_q     <= 1'b0;
            player_q    <= 1'b0;
            enable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            hold_q      <= hold_d;
            countdown_q <= countdown_d;
            lap_q       <= lap_d;
            time_q      <= time_d;
            finished_q  <= finished_d;
            bg_q        <= (state_d == ST_IDLE);
            track_q     <= (state_d != ST_IDLE);
            player_q    <= (state_d != ST_IDLE);
            enable_q    <= (state_d == ST_RACE);
        end
    end

    assign ctrl_io.game_state     = state_q;
    assign ctrl_io.countdown      = countdown_q;
    assign ctrl_io.lap_cnt        = lap_q;
    assign ctrl_io.race_time      = time_q;
    assign ctrl_io.finished       = finished_q;
    assign ctrl_io.bg_visible     = bg_q;
    assign ctrl_io.track_visible  = track_q;
    assign ctrl_io.player_visible = player_q;
    assign ctrl_io.player_enable  = enable_q;

`ifdef BEST_LAP_EN
    logic [9:0] lap_time_q, lap_time_d;
    logic [9:0] best_q, best_d;

    always_comb begin
        lap_time_d = lap_time_q;
        best_d     = best_q;
        if (state_q == ST_IDLE && start_edge) begin
            lap_time_d = '0;
        end else if (state_q == ST_RACE) begin
            if (ctrl_io.lap_cross) begin
                // A zero-second lap is shown as 1 so that 0 keeps meaning "no lap yet"
                if (lap_time_q < best_q || best_q == 10'd0)
                    best_d = (lap_time_q == 10'd0) ? 10'd1 : lap_time_q;
                lap_time_d = '0;
            end else if (sec_tick && lap_time_q != 10'h3FF) begin
                lap_time_d = lap_time_q + 10'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            lap_time_q <= '0;
            best_q     <= '0;
        end else begin
            lap_time_q <= lap_time_d;
            best_q     <= best_d;
        end
    end

    assign ctrl_io.best_lap = best_q;
`endif
endmodule
